// File: rtl/spad_mbank.sv
// Multi-bank scratchpad: one read and one write channel share BANK_NUM single-port
// banks, with alternating priority on same-bank collisions and an in-order read FIFO.

module spad_bank #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem_q [1<<ADDR_W];
    logic [DATA_W-1:0] q_q;

    // Contents are deliberately not reset so data survives a controller reset.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) mem_q[addr] <= d;
            else     q_q         <= mem_q[addr];
        end
    end

    assign q = q_q;
endmodule

module spad_mbank #(
    parameter int BANK_NUM        = 4,
    parameter int BANK_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter int RSP_DEPTH       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [DATA_WIDTH-1:0] aw_data_i,
    output logic [15:0]           conflict_cnt_o
);
    localparam int B  = $clog2(BANK_NUM);
    localparam int RA = BANK_ADDR_WIDTH;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
    } ar_req_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } aw_req_t;

    ar_req_t               ar_q, ar_d;
    aw_req_t               aw_q, aw_d;
    logic                  prev_w_q, prev_w_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [B-1:0]          rd_bank_q, rd_bank_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

    logic [B-1:0]  ar_bank, aw_bank;
    logic [RA-1:0] ar_row, aw_row;
    logic          same_bank, credit, rd_win, ar_iss, aw_iss;
    logic          pop, push, fifo_pop, fifo_nempty;
    logic [CW-1:0] logical;

    logic [BANK_NUM-1:0]                 bank_cen, bank_wen;
    logic [BANK_NUM-1:0][RA-1:0]         bank_addr;
    logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bank_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ar_bank = ar_q.addr[B-1:0];
    assign aw_bank = aw_q.addr[B-1:0];
    assign ar_row  = ar_q.addr[B+RA-1:B];
    assign aw_row  = aw_q.addr[B+RA-1:B];

    always_comb begin
        fifo_nempty = (occ_q != '0);
        // The read issued last cycle is visible straight from the bank output,
        // so it counts as a FIFO entry in the cycle its data appears.
        r_valid_o   = fifo_nempty | rd_vld_q;
        pop         = r_valid_o & r_ready_i;
        logical     = occ_q + CW'(rd_vld_q) - CW'(pop);
        credit      = logical < CW'(RSP_DEPTH);

        same_bank   = ar_q.vld & aw_q.vld & (ar_bank == aw_bank);
        rd_win      = same_bank & prev_w_q & credit;
        aw_iss      = aw_q.vld & ~rd_win;
        ar_iss      = ar_q.vld & credit & (~same_bank | rd_win);

        ar_ready_o  = ~ar_q.vld | ar_iss;
        aw_ready_o  = ~aw_q.vld | aw_iss;

        prev_w_d    = same_bank ? ~rd_win : prev_w_q;
        cnt_d       = (same_bank && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

        ar_d = ar_q;
        if (ar_valid_i && ar_ready_o) begin
            ar_d.vld  = 1'b1;
            ar_d.addr = ar_addr_i;
        end else if (ar_iss) begin
            ar_d.vld  = 1'b0;
        end

        aw_d = aw_q;
        if (aw_valid_i && aw_ready_o) begin
            aw_d.vld  = 1'b1;
            aw_d.addr = aw_addr_i;
            aw_d.data = aw_data_i;
        end else if (aw_iss) begin
            aw_d.vld  = 1'b0;
        end

        rd_vld_d  = ar_iss;
        rd_bank_d = ar_iss ? ar_bank : rd_bank_q;

        // A bypassed entry popped in its first cycle never lands in storage.
        fifo_pop  = pop & fifo_nempty;
        push      = rd_vld_q & ~(pop & ~fifo_nempty);
        rd_ptr_d  = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        occ_d     = occ_q + CW'(push) - CW'(fifo_pop);

        r_data_o = '0;
        if (fifo_nempty)   r_data_o = fifo_q[rd_ptr_q];
        else if (rd_vld_q) r_data_o = bank_q[rd_bank_q];

        for (int i = 0; i < BANK_NUM; i++) begin
            bank_wen[i]  = aw_iss & (aw_bank == B'(i));
            bank_cen[i]  = rst_n & (bank_wen[i] | (ar_iss & (ar_bank == B'(i))));
            bank_addr[i] = bank_wen[i] ? aw_row : ar_row;
        end
    end

    assign conflict_cnt_o = cnt_q;

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        spad_bank #(
            .ADDR_W (RA),
            .DATA_W (DATA_WIDTH)
        ) u_bank (
            .clk  (clk),
            .cen  (bank_cen[g]),
            .wen  (bank_wen[g]),
            .addr (bank_addr[g]),
            .d    (aw_q.data),
            .q    (bank_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= bank_q[rd_bank_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q      <= '0;
            aw_q      <= '0;
            prev_w_q  <= 1'b0;
            cnt_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_bank_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            ar_q      <= ar_d;
            aw_q      <= aw_d;
            prev_w_q  <= prev_w_d;
            cnt_q     <= cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end
endmodule

// File: tb/tb_spad_mbank.sv
// Bench for spad_mbank: a queue/array reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic and counter saturation.

module tb_spad_mbank;
    localparam int BN   = 4;
    localparam int BAW  = 4;
    localparam int DW   = 256;
    localparam int AW   = 32;
    localparam int RD   = 2;
    localparam int ROWS = 1 << BAW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ar_valid_i = 1'b0;
    logic          ar_ready_o;
    logic [AW-1:0] ar_addr_i = '0;
    logic          r_valid_o;
    logic          r_ready_i = 1'b0;
    logic [DW-1:0] r_data_o;
    logic          aw_valid_i = 1'b0;
    logic          aw_ready_o;
    logic [AW-1:0] aw_addr_i = '0;
    logic [DW-1:0] aw_data_i = '0;
    logic [15:0]   conflict_cnt_o;

    spad_mbank #(
        .BANK_NUM(BN), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .RSP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_data_i(aw_data_i), .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem [BN][ROWS];
    logic [DW-1:0] rq[$];          // every read issued before this cycle, not yet popped
    bit            arp = 0, awp = 0, last_w = 0;
    logic [AW-1:0] ara = '0, awa = '0;
    logic [DW-1:0] awd = '0;
    int            ccnt = 0;

    function automatic int bnk(input logic [AW-1:0] a);
        return int'(a % BN);
    endfunction

    function automatic int row(input logic [AW-1:0] a);
        return int'((a / BN) % ROWS);
    endfunction

    function automatic void decide(output bit pop, output bit ari, output bit awi, output bit same);
        bit credit;
        pop    = (rq.size() > 0) && r_ready_i;
        credit = (rq.size() - int'(pop)) < RD;
        same   = arp && awp && (bnk(ara) == bnk(awa));
        ari    = 0;
        awi    = 0;
        if (same) begin
            if (last_w && credit) ari = 1;
            else                  awi = 1;
        end else begin
            awi = awp;
            ari = arp && credit;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        bit pop, ari, awi, same;
        if (!rst_n) begin
            arp = 0; awp = 0; last_w = 0; ccnt = 0;
            rq.delete();
        end else begin
            decide(pop, ari, awi, same);
            if (pop) void'(rq.pop_front());
            if (ari) rq.push_back(mem[bnk(ara)][row(ara)]);
            if (awi) mem[bnk(awa)][row(awa)] = awd;
            if (same) begin
                if (ccnt < 16'hFFFF) ccnt++;
                last_w = awi;
            end
            if (ar_valid_i && (!arp || ari)) begin arp = 1; ara = ar_addr_i; end
            else if (ari) arp = 0;
            if (aw_valid_i && (!awp || awi)) begin awp = 1; awa = aw_addr_i; awd = aw_data_i; end
            else if (awi) awp = 0;
        end
    end

    int cyc_n = 0;
    int ar_hs_n = 0, aw_hs_n = 0, r_pop_n = 0;
    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin : cmp
        bit pop, ari, awi, same, mv;
        decide(pop, ari, awi, same);
        mv = rq.size() > 0;
        chk("ar_ready", DW'(ar_ready_o), DW'(!arp || ari));
        chk("aw_ready", DW'(aw_ready_o), DW'(!awp || awi));
        chk("r_valid",  DW'(r_valid_o),  DW'(mv));
        chk("r_data",   r_data_o,        mv ? rq[0] : '0);
        chk("conflict_cnt", DW'(conflict_cnt_o), DW'(ccnt));
        if (ar_valid_i && ar_ready_o) ar_hs_n++;
        if (aw_valid_i && aw_ready_o) aw_hs_n++;
        if (r_valid_o && r_ready_i)   r_pop_n++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        aw_valid_i = 1; aw_addr_i = a; aw_data_i = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); ok = aw_ready_o;
            step();
        end
        aw_valid_i = 0;
        chk("aw_handshake", DW'(ok), DW'(1));
    endtask

    task automatic rd(input logic [AW-1:0] a, output int hcyc);
        hcyc = -1;
        ar_valid_i = 1; ar_addr_i = a;
        for (int k = 0; k < 50 && hcyc < 0; k++) begin
            @(negedge clk); if (ar_ready_o) hcyc = cyc_n;
            step();
        end
        ar_valid_i = 0;
        chk("ar_handshake", DW'(hcyc >= 0), DW'(1));
    endtask

    task automatic wait_rv(output int c, output logic [DW-1:0] d);
        c = -1; d = '0;
        for (int k = 0; k < 40 && c < 0; k++) begin
            @(negedge clk);
            if (r_valid_o) begin c = cyc_n; d = r_data_o; end
        end
        chk("r_valid_wait", DW'(c >= 0), DW'(1));
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] a5, d;
        logic [AW-1:0] addrs [5];
        int h, c, c0, a0, w0, p0, idx;
        a5 = {32{8'hA5}};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ar_ready", DW'(ar_ready_o), DW'(1));
        chk("rst_aw_ready", DW'(aw_ready_o), DW'(1));
        chk("rst_r_valid",  DW'(r_valid_o),  DW'(0));
        chk("rst_r_data",   r_data_o,        DW'(0));
        chk("rst_cnt",      DW'(conflict_cnt_o), DW'(0));
        rst_n = 1;
        r_ready_i = 1;

        // initialise every row so later reads have defined contents
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < BN; b++)
                wr(AW'(r * BN + b), {8{$urandom()}});
        step();

        // write then read the same row; 2-cycle latency
        wr(AW'(5), a5);
        step(); step();
        rd(AW'(5), h);
        wait_rv(c, d);
        chk("rd_latency", DW'(c - h), DW'(2));
        chk("rd_data_a5", d, a5);
        step(); step();

        // parallel read/write on different banks
        aw_valid_i = 1; aw_addr_i = AW'(1); aw_data_i = {8{$urandom()}};
        ar_valid_i = 1; ar_addr_i = AW'(2);
        step();
        aw_valid_i = 0; ar_valid_i = 0;
        @(negedge clk);
        chk("par_ar_ready", DW'(ar_ready_o), DW'(1));
        chk("par_aw_ready", DW'(aw_ready_o), DW'(1));
        chk("par_cnt",      DW'(conflict_cnt_o), DW'(0));
        repeat (4) step();

        // same-bank conflict held 4 cycles: W,R,W,R order
        a0 = ar_hs_n; w0 = aw_hs_n;
        aw_valid_i = 1; aw_addr_i = AW'(4); aw_data_i = {8{$urandom()}};
        ar_valid_i = 1; ar_addr_i = AW'(8);
        repeat (4) step();
        aw_valid_i = 0; ar_valid_i = 0;
        chk("cf_ar_hs", DW'(ar_hs_n - a0), DW'(2));
        chk("cf_aw_hs", DW'(aw_hs_n - w0), DW'(3));
        repeat (4) step();
        chk("cf_cnt", DW'(conflict_cnt_o), DW'(4));

        // backpressure: only RSP_DEPTH responses buffered, then drain in order
        r_ready_i = 0;
        p0 = r_pop_n;
        for (int k = 0; k < 5; k++) addrs[k] = AW'(16 + 3 * k);
        idx = 0;
        ar_valid_i = 1;
        for (int k = 0; k < 8; k++) begin
            ar_addr_i = addrs[idx];
            @(negedge clk); if (ar_ready_o) idx++;
            step();
        end
        @(negedge clk);
        chk("bp_accepted", DW'(idx), DW'(3));
        chk("bp_ar_ready", DW'(ar_ready_o), DW'(0));
        chk("bp_r_valid",  DW'(r_valid_o), DW'(1));
        step();
        r_ready_i = 1;
        for (int k = 0; k < 30 && idx < 5; k++) begin
            ar_addr_i = addrs[idx];
            @(negedge clk); if (ar_ready_o) idx++;
            step();
        end
        ar_valid_i = 0;
        repeat (8) step();
        chk("bp_drained", DW'(r_pop_n - p0), DW'(5));

        // reset with two responses queued
        r_ready_i = 0;
        rd(AW'(9), h);
        rd(AW'(10), h);
        repeat (3) step();
        @(negedge clk);
        chk("rr_queued", DW'(r_valid_o), DW'(1));
        step();
        rst_n = 0;
        @(negedge clk);
        chk("rr_r_valid", DW'(r_valid_o), DW'(0));
        chk("rr_cnt",     DW'(conflict_cnt_o), DW'(0));
        step();
        rst_n = 1;
        r_ready_i = 1;
        step();
        rd(AW'(5), h);
        wait_rv(c, d);
        chk("rr_data_kept", d, a5);
        step(); step();

        // randomized traffic with occasional reset pulses
        for (int k = 0; k < 3000; k++) begin
            ar_valid_i = ($urandom_range(0, 1) == 1);
            ar_addr_i  = $urandom();
            aw_valid_i = ($urandom_range(0, 1) == 1);
            aw_addr_i  = $urandom();
            aw_data_i  = {8{$urandom()}};
            r_ready_i  = ($urandom_range(0, 9) < 7);
            rst_n      = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1; ar_valid_i = 0; aw_valid_i = 0; r_ready_i = 1;
        repeat (6) step();

        // counter saturation
        aw_valid_i = 1; aw_addr_i = AW'(4); aw_data_i = {8{$urandom()}};
        ar_valid_i = 1; ar_addr_i = AW'(8);
        repeat (70000) step();
        @(negedge clk);
        chk("sat_cnt", DW'(conflict_cnt_o), DW'(16'hFFFF));
        step();
        aw_valid_i = 0; ar_valid_i = 0;
        repeat (5) step();
        chk("sat_hold", DW'(conflict_cnt_o), DW'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
